mc_control_fsm: RTL and testbench

Main sequencer of the multi-cycle, unpipelined RV32I core. A Moore-style state machine decodes the instruction-register opcode. It steps the shared datapath through fetch, decode, execute, memory and writeback. It drives the register write strobes, the memory strobes, the ALU operand and operation selects, and the result/PC selects. Data moves through the ALU, the `alu_out` register, the register file and memory under its control; it computes nothing itself.

---
 rtl/mc_control_fsm_if.sv | 34 +++
 rtl/mc_control_fsm.sv | 195 +++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multi-cycle sequencer and the shared RV32I datapath.
// Latency: wires only; the master side's outputs are Moore outputs of the sequencer state.
// Backpressure: mem_ready stalls the memory states when the sequencer is built with MEM_WAIT_EN.
interface mc_control_fsm_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       branch_taken;
  logic       pc_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       adr_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] result_src;
  logic       illegal;
  logic [3:0] state;

  // Sequencer side: reads the IR opcode and status, drives every strobe and select.
  modport master (
    input  opcode, mem_ready, branch_taken,
    output pc_write, ir_write, reg_write, mem_read, mem_write, adr_src,
           alu_src_a, alu_src_b, alu_op, result_src, illegal, state
  );

  // Datapath side: supplies opcode and status, obeys the strobes and selects.
  modport slave (
    output opcode, mem_ready, branch_taken,
    input  pc_write, ir_write, reg_write, mem_read, mem_write, adr_src,
           alu_src_a, alu_src_b, alu_op, result_src, illegal, state
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Main sequencer of the multi-cycle RV32I core: FETCH/DECODE/EXECUTE/MEM/WB control (optional MEM_WAIT_EN).
// Latency: Moore outputs from state; 3..5 cycles per instruction, plus one per memory wait cycle.
// Backpressure: with MEM_WAIT_EN, FETCH/MEMREAD/MEMWRITE hold until mem_ready; otherwise mem_ready is ignored.
module mc_control_fsm (
  input  logic           clk,
  input  logic           rst,
  mc_control_fsm_if.master ctl
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_JAL      = 4'd9,
    S_JALR     = 4'd10,
    S_BRANCH   = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_TRAP     = 4'd14,
    S_UNUSED   = 4'd15
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_e     state_q, state_d;
  logic       mem_ok;
  logic       pc_write_c, ir_write_c, reg_write_c, mem_read_c, mem_write_c;
  logic       adr_src_c, illegal_c;
  logic [1:0] alu_src_a_c, alu_src_b_c, alu_op_c, result_src_c;

`ifdef MEM_WAIT_EN
  assign mem_ok = ctl.mem_ready;
`else
  // Memory always completes in one cycle; the ready input is deliberately ignored.
  logic unused_mem_ready;
  assign unused_mem_ready = ctl.mem_ready;
  assign mem_ok           = 1'b1;
`endif

  // State register; reset lands in FETCH asynchronously, even mid-instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state control outputs; anything not set by a state stays 0.
  always_comb begin
    state_d      = state_q;
    pc_write_c   = 1'b0;
    ir_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    adr_src_c    = 1'b0;
    illegal_c    = 1'b0;
    alu_src_a_c  = 2'b00;
    alu_src_b_c  = 2'b00;
    alu_op_c     = 2'b00;
    result_src_c = 2'b00;

    case (state_q)
      S_FETCH: begin
        // Read instruction at PC, PC+4 goes straight to the PC; IR/PC load only when the read lands.
        mem_read_c   = 1'b1;
        ir_write_c   = mem_ok;
        pc_write_c   = mem_ok;
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
        if (mem_ok) state_d = S_DECODE;
      end
      S_DECODE: begin
        // old_pc + imm is precomputed into alu_out for branches and JAL.
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b01;
        case (ctl.opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
        // opcode[5] separates store from load; the IR is still stable here.
        state_d = ctl.opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_read_c = 1'b1;
        adr_src_c  = 1'b1;
        if (mem_ok) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_c = 2'b01;
        reg_write_c  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_write_c = 1'b1;
        adr_src_c   = 1'b1;
        if (mem_ok) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a_c = 2'b10;
        alu_op_c    = 2'b10;
        state_d     = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
        alu_op_c    = 2'b10;
        state_d     = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target already in alu_out while old_pc+4 is computed for the link write.
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b10;
        pc_write_c  = 1'b1;
        state_d     = S_ALU_WB;
      end
      S_JALR: begin
        // rs1 + imm into alu_out, then reuse the JAL state for the jump and link.
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
        state_d     = S_JAL;
      end
      S_BRANCH: begin
        alu_src_a_c = 2'b10;
        alu_op_c    = 2'b01;
        pc_write_c  = ctl.branch_taken;
        state_d     = S_FETCH;
      end
      S_LUI: begin
        alu_src_a_c = 2'b11;
        alu_src_b_c = 2'b01;
        state_d     = S_ALU_WB;
      end
      S_AUIPC: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b01;
        state_d     = S_ALU_WB;
      end
      S_TRAP: begin
        illegal_c = 1'b1;
        state_d   = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Strobes are killed while reset is held; selects already show FETCH values since state_q is FETCH.
  always_comb begin
    ctl.pc_write   = rst & pc_write_c;
    ctl.ir_write   = rst & ir_write_c;
    ctl.reg_write  = rst & reg_write_c;
    ctl.mem_read   = rst & mem_read_c;
    ctl.mem_write  = rst & mem_write_c;
    ctl.adr_src    = adr_src_c;
    ctl.alu_src_a  = alu_src_a_c;
    ctl.alu_src_b  = alu_src_b_c;
    ctl.alu_op     = alu_op_c;
    ctl.result_src = result_src_c;
    ctl.illegal    = illegal_c;
    ctl.state      = state_q;
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

  logic clk;
  logic rst;

  mc_control_fsm_if bus ();

  mc_control_fsm dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       irw;
    logic       rw;
    logic       mr;
    logic       mw;
    logic       adr;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] op;
    logic [1:0] rs;
    logic       ill;
  } exp_t;

  exp_t expq[$];
  int   path_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc_no   = 0;

  logic [6:0] legal [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                            7'b1101111, 7'b1100111, 7'b1100011, 7'b0110111, 7'b0010111};

  function automatic bit is_legal(logic [6:0] opc);
    foreach (legal[i]) if (legal[i] == opc) return 1'b1;
    return 1'b0;
  endfunction

  // Instruction class -> sequence of visited states (ignoring memory wait cycles).
  function automatic void build_path(logic [6:0] opc);
    path_q = {};
    path_q.push_back(0);
    path_q.push_back(1);
    case (opc)
      7'b0000011: path_q = {path_q, 2, 3, 4};
      7'b0100011: path_q = {path_q, 2, 5};
      7'b0110011: path_q = {path_q, 6, 8};
      7'b0010011: path_q = {path_q, 7, 8};
      7'b1101111: path_q = {path_q, 9, 8};
      7'b1100111: path_q = {path_q, 10, 9, 8};
      7'b1100011: path_q = {path_q, 11};
      7'b0110111: path_q = {path_q, 12, 8};
      7'b0010111: path_q = {path_q, 13, 8};
      default:    path_q = {path_q, 14};
    endcase
  endfunction

  // Output table of each state; rdy models the memory handshake, in_rst forces strobes off.
  function automatic exp_t exp_for(int st, logic bt, logic rdy, logic in_rst);
    exp_t e;
    e    = '0;
    e.st = 4'(st);
    case (st)
      0:  begin e.mr = 1; e.b = 2'b10; e.rs = 2'b10; e.irw = rdy; e.pcw = rdy; end
      1:  begin e.a = 2'b01; e.b = 2'b01; end
      2:  begin e.a = 2'b10; e.b = 2'b01; end
      3:  begin e.mr = 1; e.adr = 1; end
      4:  begin e.rs = 2'b01; e.rw = 1; end
      5:  begin e.mw = 1; e.adr = 1; end
      6:  begin e.a = 2'b10; e.op = 2'b10; end
      7:  begin e.a = 2'b10; e.b = 2'b01; e.op = 2'b10; end
      8:  begin e.rw = 1; end
      9:  begin e.a = 2'b01; e.b = 2'b10; e.pcw = 1; end
      10: begin e.a = 2'b10; e.b = 2'b01; end
      11: begin e.a = 2'b10; e.op = 2'b01; e.pcw = bt; end
      12: begin e.a = 2'b11; e.b = 2'b01; end
      13: begin e.a = 2'b01; e.b = 2'b01; end
      14: begin e.ill = 1; end
      default: ;
    endcase
    if (in_rst) begin
      e.pcw = 0; e.irw = 0; e.rw = 0; e.mr = 0; e.mw = 0;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int n);
    rst = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.opcode       = 7'($urandom);
      bus.mem_ready    = 1'($urandom_range(0, 1));
      bus.branch_taken = 1'($urandom_range(0, 1));
      expq.push_back(exp_for(0, 1'b0, 1'b1, 1'b1));
      step();
    end
    rst = 1'b1;
  endtask

  // Drive one instruction from FETCH; optionally abort it with a reset part-way through.
  task automatic run_instr(logic [6:0] opc, logic bt, bit do_abort);
    int   abort_at;
    int   cyc;
    int   nw;
    int   st;
    logic rdy;
    build_path(opc);
    abort_at = do_abort ? $urandom_range(1, path_q.size() - 1) : -1;
    cyc = 0;
    foreach (path_q[i]) begin
      st = path_q[i];
      nw = 0;
`ifdef MEM_WAIT_EN
      if (st == 0 || st == 3 || st == 5) nw = $urandom_range(0, 2);
`endif
      for (int w = 0; w <= nw; w++) begin
        if (cyc == abort_at) begin
          do_reset(2);
          return;
        end
        rdy = (w == nw);
        bus.opcode       = (st == 0) ? 7'($urandom) : opc;
        bus.branch_taken = (st == 11) ? bt : 1'($urandom_range(0, 1));
`ifdef MEM_WAIT_EN
        bus.mem_ready    = rdy;
`else
        bus.mem_ready    = 1'($urandom_range(0, 1));
`endif
        expq.push_back(exp_for(st, bus.branch_taken, rdy, 1'b0));
        step();
        cyc++;
      end
    end
    if (!is_legal(opc)) begin
      for (int i = 0; i < 9; i++) begin
        bus.opcode = 7'($urandom);
        expq.push_back(exp_for(14, 1'b0, 1'b1, 1'b0));
        step();
      end
      do_reset(2);
    end
  endtask

  // Monitor: compares every cycle the DUT presents against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    exp_t act;
    if (expq.size() > 0) begin
      e   = expq.pop_front();
      act = '{st: bus.state, pcw: bus.pc_write, irw: bus.ir_write, rw: bus.reg_write,
              mr: bus.mem_read, mw: bus.mem_write, adr: bus.adr_src, a: bus.alu_src_a,
              b: bus.alu_src_b, op: bus.alu_op, rs: bus.result_src, ill: bus.illegal};
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL cycle_%0d outputs: actual state=%0d vec=%h, required state=%0d vec=%h",
                 cyc_no, act.st, act, e.st, e);
      end
    end
    cyc_no++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] opc;
    int         idx;
    rst              = 1'b0;
    bus.opcode       = '0;
    bus.mem_ready    = 1'b0;
    bus.branch_taken = 1'b0;
    step();
    do_reset(3);

    // Directed: add, load, store, taken/not-taken branch, JALR, LUI, AUIPC, JAL, I-type.
    run_instr(7'b0110011, 1'b0, 1'b0);
    run_instr(7'b0000011, 1'b0, 1'b0);
    run_instr(7'b0100011, 1'b0, 1'b0);
    run_instr(7'b1100011, 1'b1, 1'b0);
    run_instr(7'b1100011, 1'b0, 1'b0);
    run_instr(7'b1100111, 1'b0, 1'b0);
    run_instr(7'b0110111, 1'b0, 1'b0);
    run_instr(7'b0010111, 1'b0, 1'b0);
    run_instr(7'b1101111, 1'b0, 1'b0);
    run_instr(7'b0010011, 1'b0, 1'b0);
    // Undefined opcode 0000000: trap held 10 cycles, then reset recovers.
    run_instr(7'b0000000, 1'b0, 1'b0);
    run_instr(7'b0110011, 1'b0, 1'b0);

    // Randomized mix, with occasional illegal opcodes and mid-instruction resets.
    for (int n = 0; n < 80; n++) begin
      idx = $urandom_range(0, 15);
      if (idx == 9) begin
        do opc = 7'($urandom); while (is_legal(opc));
      end else begin
        opc = legal[idx % 9];
      end
      run_instr(opc, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) && is_legal(opc));
    end

    step();
    step();
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain: actual pending=%0d, required pending=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
